// File: rtl/keccak_pkg.sv
// Shared types, mode tables and helpers for the Keccak sponge front end.
package keccak_pkg;

    localparam int LANE_W = 64;

    localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
    localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;

    typedef enum logic [1:0] {
        MODE_SHA3_256 = 2'b00,
        MODE_SHA3_512 = 2'b01,
        MODE_SHAKE128 = 2'b10,
        MODE_SHAKE256 = 2'b11
    } keccak_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD,
        ST_DONE
    } pad_state_t;

    function automatic logic [4:0] rate_words(keccak_mode_t m);
        logic [4:0] r;
        r = 5'd17;
        case (m)
            MODE_SHA3_256: r = 5'd17;
            MODE_SHA3_512: r = 5'd9;
            MODE_SHAKE128: r = 5'd21;
            MODE_SHAKE256: r = 5'd17;
            default:       r = 5'd17;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] pad_suffix(keccak_mode_t m);
        logic [7:0] s;
        s = SUFFIX_SHA3;
        case (m)
            MODE_SHAKE128,
            MODE_SHAKE256: s = SUFFIX_SHAKE;
            default:       s = SUFFIX_SHA3;
        endcase
        return s;
    endfunction

    function automatic int cnt_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keccak_padder_countern.sv
// Word-in-block counter: wraps to zero at a runtime limit, clears on demand.
module keccak_padder_countern
    import keccak_pkg::*;
#(
    parameter int N = 21
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic [cnt_w(N)-1:0] limit,
    output logic [cnt_w(N)-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            if (count == limit) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keccak_padder.sv
// Streaming pad10*1 padder: masks the tail lane, inserts the domain suffix
// and the closing 0x80, and fills out to a whole number of rate blocks.
module keccak_padder
    import keccak_pkg::*;
#(
    parameter int W              = 64,
    parameter int LEN_W          = 32,
    parameter int MAX_RATE_WORDS = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] msg_bytes,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_block_last,
    output logic             out_msg_last,
    output logic             busy
);

    localparam int BPW = W / 8;
    localparam int CW  = cnt_w(MAX_RATE_WORDS);

    pad_state_t       state_q;
    pad_state_t       state_d;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] rem_d;
    logic [CW-1:0]    rate_m1_q;
    logic [7:0]       suffix_q;
    logic             placed_q;
    logic             placed_d;

    logic [CW-1:0]    wpos;
    logic             at_end;
    logic             adv;
    logic             start_ok;
    logic             emit;
    logic             partial;
    logic             mlast;
    logic [W-1:0]     lane;
    logic [4:0]       rw;

    assign adv      = !out_valid || out_ready;
    assign in_ready = (state_q == ST_DATA) && adv;
    assign busy     = (state_q != ST_IDLE);
    assign start_ok = (state_q == ST_IDLE) && start;
    assign at_end   = (wpos == rate_m1_q);
    assign rw       = rate_words(keccak_mode_t'(mode));

    keccak_padder_countern #(
        .N(MAX_RATE_WORDS)
    ) u_wpos (
        .clk  (clk),
        .rst  (rst),
        .clear(start_ok),
        .en   (emit),
        .limit(rate_m1_q),
        .count(wpos)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        placed_d = placed_q;
        emit     = 1'b0;
        partial  = 1'b0;
        mlast    = 1'b0;
        lane     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d    = msg_bytes;
                    placed_d = 1'b0;
                    state_d  = (msg_bytes == '0) ? ST_PAD : ST_DATA;
                end
            end
            ST_DATA: begin
                if (in_valid && in_ready) begin
                    emit    = 1'b1;
                    partial = (rem_q < LEN_W'(BPW));
                    for (int i = 0; i < BPW; i++) begin
                        if (!partial || (LEN_W'(i) < rem_q)) begin
                            lane[8*i +: 8] = in_data[8*i +: 8];
                        end else if (LEN_W'(i) == rem_q) begin
                            lane[8*i +: 8] = suffix_q;
                        end
                    end
                    if (partial) begin
                        rem_d    = '0;
                        placed_d = 1'b1;
                        if (at_end) begin
                            lane[W-1] = 1'b1;
                            mlast     = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            state_d = ST_PAD;
                        end
                    end else begin
                        // A whole lane ending the message leaves the suffix for PAD.
                        rem_d = rem_q - LEN_W'(BPW);
                        if (rem_d == '0) begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (adv) begin
                    emit     = 1'b1;
                    placed_d = 1'b1;
                    if (!placed_q) begin
                        lane[7:0] = suffix_q;
                    end
                    if (at_end) begin
                        lane[W-1] = 1'b1;
                        mlast     = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_valid && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            placed_q  <= 1'b0;
            rate_m1_q <= '0;
            suffix_q  <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            placed_q <= placed_d;
            if (start_ok) begin
                rate_m1_q <= CW'(rw - 5'd1);
                suffix_q  <= pad_suffix(keccak_mode_t'(mode));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_block_last <= 1'b0;
            out_msg_last   <= 1'b0;
        end else if (emit) begin
            out_valid      <= 1'b1;
            out_data       <= lane;
            out_block_last <= at_end;
            out_msg_last   <= mlast;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
            out_block_last <= 1'b0;
            out_msg_last   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keccak_padder.sv
// Bench for keccak_padder: vector table driven through a byte-level pad model
// feeding a scoreboard, plus hand sequences for latency, stall and reset.
module tb_keccak_padder;

    localparam int W     = 64;
    localparam int LEN_W = 32;
    localparam int MRW   = 21;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [LEN_W-1:0] msg_bytes = '0;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_block_last;
    logic             out_msg_last;
    logic             busy;

    always #5 clk = ~clk;

    keccak_padder #(
        .W(W),
        .LEN_W(LEN_W),
        .MAX_RATE_WORDS(MRW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .msg_bytes(msg_bytes),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_block_last(out_block_last),
        .out_msg_last(out_msg_last),
        .busy(busy)
    );

    typedef struct {
        logic [1:0]  mode;
        int          bytes;
        logic [63:0] word;
        int          ipct;
        int          opct;
        bit          mid;
        int          exp_lanes;
        int          chk_idx;
        logic [63:0] chk_data;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        bit          blast;
        bit          mlast;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[9];

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int tb_rate(logic [1:0] m);
        case (m)
            2'b00:   return 17;
            2'b01:   return 9;
            2'b10:   return 21;
            default: return 17;
        endcase
    endfunction

    function automatic logic [7:0] tb_suffix(logic [1:0] m);
        return m[1] ? 8'h1F : 8'h06;
    endfunction

    task automatic run_msg(input vec_t v, input int id);
        int          rate;
        int          total;
        int          nw;
        int          idx;
        int          lanes;
        int          cyc;
        bit          done;
        exp_t        e;
        logic [63:0] words[];
        logic [7:0]  pb[];
        rate  = tb_rate(v.mode);
        total = (v.bytes / (rate * 8) + 1) * rate * 8;
        nw    = (v.bytes + 7) / 8;
        idx   = 0;
        lanes = 0;
        cyc   = 0;
        done  = 0;
        words = new[(nw > 0) ? nw : 1];
        foreach (words[k])
            words[k] = (v.word != 0) ? v.word : {$urandom, $urandom};
        pb = new[total];
        foreach (pb[i]) pb[i] = 8'h00;
        for (int i = 0; i < v.bytes; i++)
            pb[i] = words[i/8][8*(i%8) +: 8];
        pb[v.bytes]  ^= tb_suffix(v.mode);
        pb[total-1]  |= 8'h80;
        for (int l = 0; l < total / 8; l++) begin
            for (int b = 0; b < 8; b++) e.data[8*b +: 8] = pb[8*l + b];
            e.blast = ((l % rate) == rate - 1);
            e.mlast = (l == total / 8 - 1);
            sbq.push_back(e);
        end
        @(negedge clk);
        mode      = v.mode;
        msg_bytes = LEN_W'(v.bytes);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        mode      = ~v.mode;
        msg_bytes = $urandom;
        check($sformatf("v%0d busy_after_start", id), 64'(busy), 64'd1);
        while (!done && cyc < 5000) begin
            cyc++;
            out_ready = ($urandom_range(99) < v.opct);
            if (idx < nw && $urandom_range(99) < v.ipct) begin
                in_valid = 1'b1;
                in_data  = words[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
            end
            if (v.mid && cyc == 8) begin
                start     = 1'b1;
                mode      = 2'b10;
                msg_bytes = 3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL v%0d extra_lane: got %h want none", id, out_data);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("v%0d lane%0d data", id, lanes), out_data, e.data);
                    check($sformatf("v%0d lane%0d flags", id, lanes),
                          64'({out_block_last, out_msg_last}), 64'({e.blast, e.mlast}));
                end
                if (lanes == v.chk_idx)
                    check($sformatf("v%0d chk_lane%0d", id, lanes), out_data, v.chk_data);
                lanes++;
                if (out_msg_last) done = 1;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        start     = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL v%0d timeout: got %0d lanes want %0d", id, lanes, v.exp_lanes);
        end
        check($sformatf("v%0d lane_count", id), 64'(lanes), 64'(v.exp_lanes));
        check($sformatf("v%0d sb_left", id), 64'(sbq.size()), 64'd0);
        check($sformatf("v%0d busy_after_last", id), 64'(busy), 64'd0);
        sbq.delete();
    endtask

    task automatic drain(output int cnt);
        int cyc;
        bit fin;
        cyc = 0;
        fin = 0;
        cnt = 0;
        out_ready = 1'b1;
        while (!fin && cyc < 200) begin
            #1;
            if (out_valid) begin
                cnt++;
                fin = out_msg_last;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d lanes want msg_last", cnt);
        end
    endtask

    initial begin
        int   cnt;
        int   cyc;
        vec_t rv;

        vecs[0] = '{2'b10,   0, 64'h0,                  100, 100, 1'b0, 21, 20, 64'h8000_0000_0000_0000};
        vecs[1] = '{2'b00,   5, 64'h1122_3344_5566_7788, 100, 100, 1'b0, 17,  0, 64'h0000_0644_5566_7788};
        vecs[2] = '{2'b11, 135, 64'hA5A5_A5A5_A5A5_A5A5, 100, 100, 1'b0, 17, 16, 64'h9FA5_A5A5_A5A5_A5A5};
        vecs[3] = '{2'b11, 136, 64'h0123_4567_89AB_CDEF, 100, 100, 1'b0, 34, 17, 64'h0000_0000_0000_001F};
        vecs[4] = '{2'b01, 200, 64'h0,                   70,  60, 1'b1, 27, 25, 64'h0000_0000_0000_0006};
        vecs[5] = '{2'b01,  72, 64'h0,                  100, 100, 1'b0, 18,  9, 64'h0000_0000_0000_0006};
        vecs[6] = '{2'b00,   7, 64'hFFFF_FFFF_FFFF_FFFF, 100, 100, 1'b0, 17,  0, 64'h06FF_FFFF_FFFF_FFFF};
        vecs[7] = '{2'b01,  71, 64'h1111_1111_1111_1111, 100, 100, 1'b0,  9,  8, 64'h8611_1111_1111_1111};
        vecs[8] = '{2'b10, 168, 64'h0,                   50,  50, 1'b0, 42, 21, 64'h0000_0000_0000_001F};

        #1 rst = 1'b1;
        #2;
        check("reset_data", out_data, 64'h0);
        check("reset_flags",
              64'({out_valid, out_block_last, out_msg_last, in_ready, busy}), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_msg(vecs[i], i);

        @(negedge clk);
        mode      = 2'b10;
        msg_bytes = 0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pad_busy_t1", 64'(busy), 64'd1);
        check("pad_valid_t1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("pad_valid_t2", 64'(out_valid), 64'd1);
        check("pad_lane0_t2", out_data, 64'h1F);
        @(negedge clk);
        check("stall_hold_valid", 64'({out_valid, out_block_last}), 64'b10);
        check("stall_hold_data", out_data, 64'h1F);
        drain(cnt);
        check("pad_only_lanes", 64'(cnt), 64'd21);
        check("idle_after_last", 64'(busy), 64'd0);
        mode      = 2'b01;
        msg_bytes = 0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        @(negedge clk);
        drain(cnt);
        check("restart_lanes", 64'(cnt), 64'd9);

        mode      = 2'b10;
        msg_bytes = 200;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        cyc   = 0;
        while (cnt < 5 && cyc < 100) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            #1;
            if (out_valid && out_ready) cnt++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_data", out_data, 64'h0);
        check("midrst_flags",
              64'({out_valid, out_block_last, out_msg_last, in_ready, busy}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        rv  = '{2'b10, 8, 64'h0, 100, 100, 1'b0, 21, 1, 64'h0000_0000_0000_001F};
        run_msg(rv, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
